// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC sequencing, imem requests, redirect and stale-response discard
module fetch_unit #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  input  logic            stall_i,
  input  logic            branch,
  input  logic            jump,
  input  logic            zero,
  input  logic [XLEN-1:0] pc_target,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            instr_valid_o
);

  typedef enum logic [1:0] {
    S_BOOT    = 2'd0,
    S_FETCH   = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  localparam logic [31:0]     NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  state_t            r_state;
  logic [XLEN-1:0]   r_fetch_pc;
  logic [XLEN-1:0]   r_req_addr;
  logic [31:0]       r_instr;
  logic [XLEN-1:0]   r_pc;
  logic              r_valid;

  state_t            w_state_nxt;
  logic [XLEN-1:0]   w_fetch_pc_nxt;
  logic [XLEN-1:0]   w_req_addr_nxt;
  logic [31:0]       w_instr_nxt;
  logic [XLEN-1:0]   w_pc_nxt;
  logic              w_valid_nxt;
  logic              w_req;
  logic [XLEN-1:0]   w_addr;
  logic              w_consume;
  logic              w_pc_src;
  logic              w_redirect;

  assign w_consume  = r_valid & ~stall_i;
  assign w_pc_src   = jump | (branch & zero);
  assign w_redirect = w_consume & w_pc_src;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_BOOT;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_instr    <= NOP;
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_addr <= w_req_addr_nxt;
      r_instr    <= w_instr_nxt;
      r_pc       <= w_pc_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_addr_nxt = r_req_addr;
    w_instr_nxt    = r_instr;
    w_pc_nxt       = r_pc;
    w_valid_nxt    = r_valid;
    w_req          = 1'b0;
    w_addr         = r_fetch_pc;

    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_FETCH;
      end

      S_FETCH: begin
        // Only request when the slot is free next cycle, so any response can be captured.
        w_req          = ~r_valid | w_consume;
        w_addr         = r_fetch_pc;
        w_req_addr_nxt = r_fetch_pc;
        if (w_redirect) begin
          w_valid_nxt    = 1'b0;
          w_fetch_pc_nxt = pc_target & ALIGN_MASK;
          if (w_req && !imem_valid) begin
            w_state_nxt = S_DISCARD;
          end
        end else if (w_req && imem_valid) begin
          w_instr_nxt    = imem_rdata;
          w_pc_nxt       = r_fetch_pc;
          w_valid_nxt    = 1'b1;
          w_fetch_pc_nxt = r_fetch_pc + PC_STEP;
        end else if (w_consume) begin
          w_valid_nxt = 1'b0;
        end
      end

      S_DISCARD: begin
        // Keep the abandoned request stable until memory answers it, then drop the data.
        w_req  = 1'b1;
        w_addr = r_req_addr;
        if (imem_valid) begin
          w_state_nxt = S_FETCH;
        end
      end

      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  assign imem_req      = w_req;
  assign imem_addr     = w_addr;
  assign instr_o       = r_instr;
  assign pc_o          = r_pc;
  assign pc_plus4_o    = r_pc + PC_STEP;
  assign instr_valid_o = r_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: vector table, corner sequences, random run vs program-flow model
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall_i, branch, jump, zero;
  logic [31:0] pc_target;
  logic [31:0] instr_o, pc_o, pc_plus4_o;
  logic        instr_valid_o;

  int checks = 0;
  int errors = 0;
  int lat = 0;
  int mem_cnt = 0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .stall_i(stall_i), .branch(branch), .jump(jump), .zero(zero), .pc_target(pc_target),
    .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .instr_valid_o(instr_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A00_0001;
  endfunction

  // Memory answers once the request has waited lat cycles (lat=0: same cycle).
  always_comb begin
    imem_valid = imem_req && (mem_cnt >= lat);
    imem_rdata = imem_valid ? mem_word(imem_addr) : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (!rst_n) mem_cnt <= 0;
    else if (imem_req && imem_valid) mem_cnt <= 0;
    else if (imem_req) mem_cnt <= mem_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    stall_i = 0; branch = 0; jump = 0; zero = 0; pc_target = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    ok = 0;
    for (int k = 0; k < bound; k++) begin
      if (instr_valid_o) begin
        ok = 1;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic        stall, br, jmp, zr;
    logic [31:0] target;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t tbl[15];

  initial begin
    bit ok;
    int found;
    int consumes;
    logic [31:0] exp_pc;
    logic        prev_req, prev_ack;
    logic [31:0] prev_addr;

    // Cycle-by-cycle after reset release, zero-wait memory.
    tbl[0]  = '{0,0,0,0,32'h0,   0,32'h000,0,32'h000,NOP};
    tbl[1]  = '{0,0,0,0,32'h0,   1,32'h000,0,32'h000,NOP};
    tbl[2]  = '{0,0,0,0,32'h0,   1,32'h004,1,32'h000,mem_word(32'h000)};
    tbl[3]  = '{0,0,0,0,32'h0,   1,32'h008,1,32'h004,mem_word(32'h004)};
    tbl[4]  = '{1,0,0,0,32'h0,   0,32'h00C,1,32'h008,mem_word(32'h008)};
    tbl[5]  = '{1,0,0,0,32'h0,   0,32'h00C,1,32'h008,mem_word(32'h008)};
    tbl[6]  = '{1,0,0,0,32'h0,   0,32'h00C,1,32'h008,mem_word(32'h008)};
    tbl[7]  = '{0,1,0,1,32'h40,  1,32'h00C,1,32'h008,mem_word(32'h008)};
    tbl[8]  = '{0,0,0,0,32'h0,   1,32'h040,0,32'h008,mem_word(32'h008)};
    tbl[9]  = '{0,1,0,0,32'h80,  1,32'h044,1,32'h040,mem_word(32'h040)};
    tbl[10] = '{0,0,1,0,32'h103, 1,32'h048,1,32'h044,mem_word(32'h044)};
    tbl[11] = '{0,0,0,0,32'h0,   1,32'h100,0,32'h044,mem_word(32'h044)};
    tbl[12] = '{1,1,0,1,32'h200, 0,32'h104,1,32'h100,mem_word(32'h100)};
    tbl[13] = '{0,0,0,0,32'h0,   1,32'h104,1,32'h100,mem_word(32'h100)};
    tbl[14] = '{0,0,0,0,32'h0,   1,32'h108,1,32'h104,mem_word(32'h104)};

    rst_n = 0;
    clear_inputs();
    lat = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst%0d_req", c), 32'(imem_req), 32'h0);
      chk($sformatf("rst%0d_valid", c), 32'(instr_valid_o), 32'h0);
      chk($sformatf("rst%0d_pc", c), pc_o, 32'h0);
      chk($sformatf("rst%0d_instr", c), instr_o, NOP);
    end
    rst_n = 1;

    for (int i = 0; i < 15; i++) begin
      stall_i = tbl[i].stall; branch = tbl[i].br; jump = tbl[i].jmp;
      zero = tbl[i].zr; pc_target = tbl[i].target;
      #1;
      chk($sformatf("row%0d_req", i), 32'(imem_req), 32'(tbl[i].exp_req));
      chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("row%0d_valid", i), 32'(instr_valid_o), 32'(tbl[i].exp_valid));
      chk($sformatf("row%0d_pc", i), pc_o, tbl[i].exp_pc);
      chk($sformatf("row%0d_pc4", i), pc_plus4_o, tbl[i].exp_pc + 32'd4);
      chk($sformatf("row%0d_instr", i), instr_o, tbl[i].exp_instr);
      @(negedge clk);
    end
    clear_inputs();

    // Slow memory: jump while the 0xC request is outstanding must discard it.
    do_reset();
    lat = 3;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (instr_valid_o && pc_o == 32'h8) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("disc_reach", 32'(found), 32'h1);
    jump = 1; pc_target = 32'h102;
    #1;
    chk("disc_req0", 32'(imem_req), 32'h1);
    chk("disc_addr0", imem_addr, 32'hC);
    @(negedge clk);
    jump = 0; pc_target = 0;
    #1;
    chk("disc_valid", 32'(instr_valid_o), 32'h0);
    found = 0;
    for (int k = 0; k < 10; k++) begin
      chk("disc_hold_req", 32'(imem_req), 32'h1);
      chk("disc_hold_addr", imem_addr, 32'hC);
      chk("disc_hold_valid", 32'(instr_valid_o), 32'h0);
      if (imem_valid) begin
        found = 1;
        break;
      end
      @(negedge clk);
      #1;
    end
    chk("disc_ack", 32'(found), 32'h1);
    @(negedge clk);
    #1;
    chk("disc_newreq", 32'(imem_req), 32'h1);
    chk("disc_newaddr", imem_addr, 32'h100);
    chk("disc_nostale", 32'(instr_valid_o), 32'h0);
    wait_valid(20, ok);
    chk("disc_wait", 32'(ok), 32'h1);
    chk("disc_pc", pc_o, 32'h100);
    chk("disc_instr", instr_o, mem_word(32'h100));

    // Address wrap at the top of the address space.
    lat = 0;
    jump = 1; pc_target = 32'hFFFF_FFFE;
    #1;
    @(negedge clk);
    jump = 0; pc_target = 0;
    #1;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_bubble", 32'(instr_valid_o), 32'h0);
    @(negedge clk);
    #1;
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4_o, 32'h0);
    chk("wrap_instr", instr_o, mem_word(32'hFFFF_FFFC));
    chk("wrap_next_addr", imem_addr, 32'h0);
    @(negedge clk);
    #1;
    chk("wrap_pc0", pc_o, 32'h0);
    chk("wrap_valid0", 32'(instr_valid_o), 32'h1);

    // Reset while discarding: nothing stale may surface afterwards.
    lat = 3;
    jump = 1; pc_target = 32'h20;
    #1;
    @(negedge clk);
    jump = 0; pc_target = 0;
    #1;
    chk("rd_disc_addr", imem_addr, 32'h4);
    chk("rd_disc_req", 32'(imem_req), 32'h1);
    rst_n = 0;
    @(negedge clk);
    #1;
    chk("rd_req", 32'(imem_req), 32'h0);
    chk("rd_valid", 32'(instr_valid_o), 32'h0);
    chk("rd_instr", instr_o, NOP);
    chk("rd_pc", pc_o, 32'h0);
    rst_n = 1;
    #1;
    chk("rd_boot_req", 32'(imem_req), 32'h0);
    @(negedge clk);
    #1;
    chk("rd_fetch_req", 32'(imem_req), 32'h1);
    chk("rd_fetch_addr", imem_addr, 32'h0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rd_nostale%0d", k), 32'(instr_valid_o), 32'h0);
      @(negedge clk);
      #1;
    end
    wait_valid(20, ok);
    chk("rd_first_pc", pc_o, 32'h0);
    chk("rd_first_instr", instr_o, mem_word(32'h0));

    // Random run: every consumed instruction must follow the program-flow rule.
    do_reset();
    exp_pc = 32'h0;
    consumes = 0;
    prev_req = 0; prev_ack = 0; prev_addr = 0;
    for (int n = 0; n < 4000; n++) begin
      stall_i   = ($urandom % 4) == 0;
      branch    = ($urandom % 6) == 0;
      zero      = $urandom % 2;
      jump      = ($urandom % 12) == 0;
      pc_target = $urandom;
      lat       = $urandom_range(0, 3);
      #1;
      if (prev_req && !prev_ack) begin
        chk("rnd_req_held", 32'(imem_req), 32'h1);
        chk("rnd_addr_held", imem_addr, prev_addr);
      end
      if (imem_req) chk("rnd_align", 32'(imem_addr[1:0]), 32'h0);
      if (instr_valid_o) chk("rnd_pc4", pc_plus4_o, pc_o + 32'd4);
      if (instr_valid_o && !stall_i) begin
        consumes++;
        chk("rnd_pc", pc_o, exp_pc);
        chk("rnd_instr", instr_o, mem_word(exp_pc));
        if (jump || (branch && zero)) exp_pc = {pc_target[31:2], 2'b00};
        else exp_pc = exp_pc + 32'd4;
      end
      prev_req  = imem_req;
      prev_ack  = imem_valid;
      prev_addr = imem_addr;
      @(negedge clk);
    end
    chk("rnd_progress", 32'(consumes >= 300), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
